// File: rtl/fifo_read_stream.sv
// fifo_read_stream
// Read-side drain stage for the async FIFO, entirely in the read_clk domain.
// Pops words from the FIFO and re-presents them on a valid/ready stream using
// a 2-entry buffer (slot0 = output register, slot1 = skid slot). Because of
// the skid slot, read_inc never depends on out_ready.
//
// Ports:
//   read_clk       read-domain clock (rising edge)
//   read_reset     asynchronous, active-high reset
//   fifo_empty     FIFO empty flag
//   fifo_data      FIFO read data, valid whenever fifo_empty=0
//   read_inc       FIFO pop strobe
//   flush          synchronous discard of all buffered words
//   out_data       stream data (slot0)
//   out_valid      stream valid
//   out_ready      stream ready from the consumer
//   deliver_count  completed handshakes, wraps modulo 2^CNT_SIZE
//   stall_count    (FIFO_STREAM_STATS_EN only) saturating stall-cycle counter
//   starve_count   (FIFO_STREAM_STATS_EN only) saturating starve-cycle counter
//
// Optional feature macro: FIFO_STREAM_STATS_EN
module fifo_read_stream #(
  parameter int DATA_SIZE = 8,
  parameter int CNT_SIZE  = 16
) (
  input  logic                 read_clk,
  input  logic                 read_reset,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 read_inc,
  input  logic                 flush,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_SIZE-1:0]  deliver_count
`ifdef FIFO_STREAM_STATS_EN
  ,
  output logic [CNT_SIZE-1:0]  stall_count,
  output logic [CNT_SIZE-1:0]  starve_count
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]           count;
  logic [DATA_SIZE-1:0] slot0;
  logic [DATA_SIZE-1:0] slot1;
  logic                 push;
  logic                 pop;

  assign out_valid = (count != EMPTY);
  assign out_data  = slot0;
  assign read_inc  = !fifo_empty && (count != TWO) && !flush && !read_reset;
  assign push      = read_inc;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge read_clk or posedge read_reset) begin
    if (read_reset) begin
      count <= EMPTY;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= EMPTY;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case (count)
        EMPTY: begin
          if (push) begin
            count <= ONE;
            slot0 <= fifo_data;
          end
        end
        ONE: begin
          if (push && !pop) begin
            count <= TWO;
            slot1 <= fifo_data;
          end else if (push && pop) begin
            slot0 <= fifo_data;
          end else if (pop) begin
            count <= EMPTY;
          end
        end
        TWO: begin
          // push cannot occur here: read_inc is masked while count is TWO
          if (pop) begin
            count <= ONE;
            slot0 <= slot1;
          end
        end
        default: count <= EMPTY;
      endcase
    end
  end

  // Handshakes in a flush cycle still count, so this is independent of flush.
  always_ff @(posedge read_clk or posedge read_reset) begin
    if (read_reset) begin
      deliver_count <= '0;
    end else if (pop) begin
      deliver_count <= deliver_count + 1'b1;
    end
  end

`ifdef FIFO_STREAM_STATS_EN
  always_ff @(posedge read_clk or posedge read_reset) begin
    if (read_reset) begin
      stall_count  <= '0;
      starve_count <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (out_ready && !out_valid && !flush && (starve_count != '1))
        starve_count <= starve_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_stream.sv
// Testbench for fifo_read_stream. A queue-based reference model holds the
// FIFO contents (src_q) and the words in flight inside the stage (exp_q).
module tb_fifo_read_stream;

  logic       read_clk;
  logic       read_reset;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       read_inc;
  logic       flush;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] deliver_count;
`ifdef FIFO_STREAM_STATS_EN
  logic [3:0] stall_count;
  logic [3:0] starve_count;
`endif

  fifo_read_stream #(.DATA_SIZE(8), .CNT_SIZE(4)) dut (
    .read_clk      (read_clk),
    .read_reset    (read_reset),
    .fifo_empty    (fifo_empty),
    .fifo_data     (fifo_data),
    .read_inc      (read_inc),
    .flush         (flush),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .deliver_count (deliver_count)
`ifdef FIFO_STREAM_STATS_EN
    ,
    .stall_count   (stall_count),
    .starve_count  (starve_count)
`endif
  );

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  logic [7:0]  src_q[$];
  logic [7:0]  exp_q[$];
  bit          hold_empty;
  int unsigned m_cnt, m_stall, m_starve;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 0; m_stall = 0; m_starve = 0;
  endtask

  // One clock cycle: present FIFO side, check outputs, advance model at the edge.
  task automatic tick();
    bit e_inc, e_valid, pop;
    fifo_empty = hold_empty || (src_q.size() == 0);
    fifo_data  = fifo_empty ? 8'($urandom) : src_q[0];
    #2;
    e_valid = (exp_q.size() != 0);
    e_inc   = !fifo_empty && (exp_q.size() < 2) && !flush && !read_reset;
    chk("read_inc", 32'(read_inc), 32'(e_inc));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    if (e_valid) chk("out_data", 32'(out_data), 32'(exp_q[0]));
    chk("deliver_count", 32'(deliver_count), m_cnt % 16);
`ifdef FIFO_STREAM_STATS_EN
    chk("stall_count", 32'(stall_count), m_stall);
    chk("starve_count", 32'(starve_count), m_starve);
`endif
    pop = e_valid && out_ready;
    @(posedge read_clk);
    if (read_reset) begin
      model_reset();
    end else begin
      if (e_valid && !out_ready && m_stall < 15) m_stall++;
      if (!e_valid && out_ready && !flush && m_starve < 15) m_starve++;
      if (pop) begin
        void'(exp_q.pop_front());
        m_cnt++;
      end
      if (flush) exp_q.delete();
      else if (e_inc) exp_q.push_back(src_q.pop_front());
    end
    #1;
  endtask

  initial begin
    int unsigned c0;
    read_reset = 1'b1; flush = 1'b0; out_ready = 1'b1; hold_empty = 1'b1;
    fifo_empty = 1'b1; fifo_data = '0;
    model_reset();
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_deliver", 32'(deliver_count), 0);
    chk("rst_read_inc", 32'(read_inc), 0);
    #9 read_reset = 1'b0;

    // Idle with an empty FIFO.
    repeat (10) tick();

    // Four words, consumer always ready.
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    hold_empty = 1'b0;
    c0 = m_cnt;
    repeat (7) tick();
    chk("burst_delivered", 32'(m_cnt - c0), 4);
    chk("burst_src_drained", 32'(src_q.size()), 0);

    // Four words, consumer stalled: only two pops, then release.
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1'b0;
    repeat (6) tick();
    chk("stall_src_left", 32'(src_q.size()), 2);
    chk("stall_hold_data", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    repeat (6) tick();

    // Long stall saturates the stall counter.
    src_q = '{8'h55, 8'h66};
    out_ready = 1'b0;
    repeat (20) tick();
`ifdef FIFO_STREAM_STATS_EN
    chk("stall_sat", 32'(stall_count), 15);
`endif
    out_ready = 1'b1;
    repeat (4) tick();

    // Flush while holding two words: they must never be delivered.
    src_q = '{8'hA0, 8'hA1, 8'hB0};
    out_ready = 1'b0;
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    tick();
    chk("flush_next_word", 32'(out_data), 32'hB0);
    repeat (3) tick();

    // Asynchronous reset mid-stream with two words buffered.
    src_q = '{8'hC0, 8'hC1, 8'hC2};
    out_ready = 1'b0;
    repeat (2) tick();
    #1 read_reset = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_data", 32'(out_data), 0);
    chk("async_deliver", 32'(deliver_count), 0);
    chk("async_read_inc", 32'(read_inc), 0);
    model_reset();
    repeat (3) tick();
    chk("reset_no_pop", 32'(src_q.size()), 1);
    read_reset = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if (src_q.size() < 3) src_q.push_back(8'($urandom));
      out_ready  = ($urandom_range(0, 9) < 7);
      hold_empty = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
